// File: rtl/serial_rx_param_if.sv
// Line-side input and word-side valid/ready output of the parametrised serial receiver.
interface serial_rx_param_if #(
  parameter int DATA_BITS = 7
);
  logic                 serial_in;
  logic                 out_ready;
  logic                 out_valid;
  logic [DATA_BITS-1:0] data_out;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  serial_in,
    input  out_ready,
    output out_valid,
    output data_out,
    output parity_err,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output serial_in,
    output out_ready,
    input  out_valid,
    input  data_out,
    input  parity_err,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/serial_rx_param.sv
// Deframes start / DATA_BITS data (LSB first) / optional parity / stop bits with mid-bit
// sampling, then holds the word with its error flags behind a valid/ready handshake.
module serial_rx_param #(
  parameter int DATA_BITS    = 7,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  serial_rx_param_if.master  bus
);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int BMAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BW   = $clog2(BMAX + 1);
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'((HALF > 0) ? (HALF - 1) : 0);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_baud;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_acc;
  logic                 r_perr_frame;
  logic                 r_ferr_frame;
  logic                 r_valid;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_ovr;

  logic                 w_tick;
  logic                 w_accept;
  logic                 w_done;
  logic                 w_ferr_final;
  logic                 w_par_err;
  logic [DATA_BITS-1:0] w_shift_in;

  assign w_tick       = (r_baud == '0);
  assign w_accept     = r_valid && bus.out_ready;
  assign w_done       = (r_state == S_STOP) && w_tick && (r_bit == LAST_STOP);
  assign w_ferr_final = r_ferr_frame | ~bus.serial_in;
  assign w_par_err    = (PARITY == 0) ? 1'b0 :
                        (PARITY == 1) ? (r_par_acc ^ bus.serial_in) :
                                        ~(r_par_acc ^ bus.serial_in);

  generate
    if (DATA_BITS == 1) begin : g_shift_one
      assign w_shift_in = bus.serial_in;
    end else begin : g_shift_many
      assign w_shift_in = {bus.serial_in, r_shift[DATA_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_baud       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_par_acc    <= 1'b0;
      r_perr_frame <= 1'b0;
      r_ferr_frame <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_ovr        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!bus.serial_in) begin
            r_bit        <= '0;
            r_par_acc    <= 1'b0;
            r_perr_frame <= 1'b0;
            r_ferr_frame <= 1'b0;
            // With no half-bit delay the start sample is this very cycle.
            if (HALF == 0) begin
              r_state <= S_DATA;
              r_baud  <= CNT_FULL;
            end else begin
              r_state <= S_START;
              r_baud  <= CNT_HALF;
            end
          end
        end
        S_START: begin
          if (!w_tick) begin
            r_baud <= r_baud - 1'b1;
          end else if (bus.serial_in) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DATA;
            r_baud  <= CNT_FULL;
          end
        end
        S_DATA: begin
          if (!w_tick) begin
            r_baud <= r_baud - 1'b1;
          end else begin
            r_baud    <= CNT_FULL;
            r_shift   <= w_shift_in;
            r_par_acc <= r_par_acc ^ bus.serial_in;
            if (r_bit == LAST_DATA) begin
              r_bit   <= '0;
              r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (!w_tick) begin
            r_baud <= r_baud - 1'b1;
          end else begin
            r_baud       <= CNT_FULL;
            r_perr_frame <= w_par_err;
            r_state      <= S_STOP;
          end
        end
        S_STOP: begin
          if (!w_tick) begin
            r_baud <= r_baud - 1'b1;
          end else begin
            r_baud       <= CNT_FULL;
            r_ferr_frame <= w_ferr_final;
            if (r_bit == LAST_STOP) begin
              r_state <= w_ferr_final ? S_BREAK : S_IDLE;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (bus.serial_in) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A completing frame replaces the held word only if the slot is free or being emptied.
      if (w_done && (!r_valid || w_accept)) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
        r_perr  <= r_perr_frame;
        r_ferr  <= w_ferr_final;
        r_ovr   <= 1'b0;
      end else if (w_done) begin
        r_ovr <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = r_valid;
  assign bus.data_out   = r_data;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;
  assign bus.overrun    = r_ovr;
  assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_serial_rx_param.sv
// Drives frames into four receiver configurations and compares presented words with a
// bit-list model of the frame format and its sample-point latency.
module tb_serial_rx_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] line  = 4'hF;
  logic [3:0] ready = 4'hF;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_rx_param_if #(.DATA_BITS(7)) if0 ();
  serial_rx_param_if #(.DATA_BITS(7)) if1 ();
  serial_rx_param_if #(.DATA_BITS(7)) if2 ();
  serial_rx_param_if #(.DATA_BITS(8)) if3 ();

  serial_rx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  serial_rx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  serial_rx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(4))
    dut2 (.clk(clk), .rst(rst), .bus(if2));
  serial_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(3))
    dut3 (.clk(clk), .rst(rst), .bus(if3));

  assign if0.serial_in = line[0];
  assign if1.serial_in = line[1];
  assign if2.serial_in = line[2];
  assign if3.serial_in = line[3];
  assign if0.out_ready = ready[0];
  assign if1.out_ready = ready[1];
  assign if2.out_ready = ready[2];
  assign if3.out_ready = ready[3];

  wire [3:0]  vld;
  wire [3:0]  perr_o;
  wire [3:0]  ferr_o;
  wire [3:0]  ovr_o;
  wire [3:0]  busy_o;
  wire [15:0] dout [4];

  assign vld[0] = if0.out_valid;   assign dout[0] = 16'(if0.data_out);
  assign vld[1] = if1.out_valid;   assign dout[1] = 16'(if1.data_out);
  assign vld[2] = if2.out_valid;   assign dout[2] = 16'(if2.data_out);
  assign vld[3] = if3.out_valid;   assign dout[3] = 16'(if3.data_out);
  assign perr_o = {if3.parity_err, if2.parity_err, if1.parity_err, if0.parity_err};
  assign ferr_o = {if3.frame_err, if2.frame_err, if1.frame_err, if0.frame_err};
  assign ovr_o  = {if3.overrun, if2.overrun, if1.overrun, if0.overrun};
  assign busy_o = {if3.busy, if2.busy, if1.busy, if0.busy};

  typedef struct {
    int          inst;
    logic [15:0] data;
    logic        perr;
    logic        ferr;
    int          cyc;
  } word_t;

  word_t got_q[$];
  logic [3:0] pv   = 4'h0;
  logic [3:0] pacc = 4'h0;

  // Log every newly presented word (first valid cycle, or valid right after an accept).
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld[i] && (!pv[i] || pacc[i])) begin
        word_t w;
        w.inst = i;
        w.data = dout[i];
        w.perr = perr_o[i];
        w.ferr = ferr_o[i];
        w.cyc  = cyc;
        got_q.push_back(w);
      end
    end
    pv   <= vld;
    pacc <= vld & ready;
  end

  function automatic int cfg_db(input int i);
    return (i == 3) ? 8 : 7;
  endfunction
  function automatic int cfg_par(input int i);
    return (i == 1) ? 2 : ((i == 3) ? 0 : 1);
  endfunction
  function automatic int cfg_sb(input int i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic int cfg_c(input int i);
    return (i == 2) ? 4 : ((i == 3) ? 3 : 1);
  endfunction

  task automatic idle(input int i, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      line[i] = 1'b1;
    end
  endtask

  // Builds the frame as a list of line bits, drives it, and returns the expected word.
  task automatic send_frame(input int i, input logic [15:0] d, input bit pflip,
                            input bit [1:0] szero, input bit ready_at_end, output word_t exp);
    int db, par, sb, c, half, n, t0;
    bit b[32];
    logic p;
    logic [15:0] m;
    db = cfg_db(i); par = cfg_par(i); sb = cfg_sb(i); c = cfg_c(i);
    half = (c - 1) / 2;
    n = 0; t0 = 0; p = 1'b0;
    b[n] = 1'b0; n++;
    for (int k = 0; k < db; k++) begin
      b[n] = d[k]; p = p ^ d[k]; n++;
    end
    if (par != 0) begin
      b[n] = ((par == 2) ? ~p : p) ^ pflip; n++;
    end
    exp.ferr = 1'b0;
    for (int k = 0; k < sb; k++) begin
      b[n] = ~szero[k]; n++;
      if (szero[k]) exp.ferr = 1'b1;
    end
    m = (db >= 16) ? 16'hFFFF : 16'((32'd1 << db) - 1);
    exp.inst = i;
    exp.data = d & m;
    exp.perr = (par != 0) && pflip;
    for (int k = 0; k < n; k++) begin
      for (int cc = 0; cc < c; cc++) begin
        @(posedge clk); #1;
        if (k == 0 && cc == 0) t0 = cyc;
        line[i] = b[k];
        if (ready_at_end) ready[i] = (k == n - 1) && (cc == half);
      end
    end
    exp.cyc = t0 + (n - 1) * c + half + 1;
    if (ready_at_end) begin
      @(posedge clk); #1;
      ready[i] = 1'b0;
      line[i]  = 1'b1;
    end
  endtask

  task automatic wait_word(input word_t e, input string nm);
    word_t w;
    int guard = 0;
    while (got_q.size() == 0 && guard < 300) begin
      @(negedge clk); #1;
      guard++;
    end
    checks++;
    if (got_q.size() == 0) begin
      errors++;
      $display("FAIL %s_present: got no word, required data %h", nm, e.data);
      return;
    end
    w = got_q.pop_front();
    checks++;
    if (w.inst !== e.inst) begin errors++; $display("FAIL %s_inst: got %0d required %0d", nm, w.inst, e.inst); end
    checks++;
    if (w.data !== e.data) begin errors++; $display("FAIL %s_data: got %h required %h", nm, w.data, e.data); end
    checks++;
    if (w.perr !== e.perr) begin errors++; $display("FAIL %s_perr: got %b required %b", nm, w.perr, e.perr); end
    checks++;
    if (w.ferr !== e.ferr) begin errors++; $display("FAIL %s_ferr: got %b required %b", nm, w.ferr, e.ferr); end
    checks++;
    if (w.cyc !== e.cyc) begin errors++; $display("FAIL %s_latency: got cycle %0d required %0d", nm, w.cyc, e.cyc); end
    $display("word %s inst=%0d data=%h perr=%b ferr=%b cyc=%0d", nm, w.inst, w.data, w.perr, w.ferr, w.cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({vld[i], perr_o[i], ferr_o[i], ovr_o[i], busy_o[i]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_flags inst%0d: got %b required 00000", i,
                 {vld[i], perr_o[i], ferr_o[i], ovr_o[i], busy_o[i]});
      end
      checks++;
      if (dout[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset_data inst%0d: got %h required 0000", i, dout[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset done");
  endtask

  task automatic test_basic();
    word_t e;
    send_frame(0, 16'h41, 1'b0, 2'b00, 1'b0, e);
    idle(0, 3);
    wait_word(e, "basic");
  endtask

  task automatic test_parity();
    word_t e;
    send_frame(0, 16'h41, 1'b1, 2'b00, 1'b0, e);
    idle(0, 3);
    wait_word(e, "even_bad_parity");
    send_frame(1, 16'h41, 1'b0, 2'b00, 1'b0, e);
    idle(1, 3);
    wait_word(e, "odd_parity");
  endtask

  task automatic test_false_start();
    word_t e;
    @(posedge clk); #1;
    line[2] = 1'b0;
    @(posedge clk); #1;
    line[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o[2] !== 1'b1) begin errors++; $display("FAIL false_start_busy_t1: got %b required 1", busy_o[2]); end
    @(negedge clk);
    checks++;
    if (busy_o[2] !== 1'b0) begin errors++; $display("FAIL false_start_busy_t2: got %b required 0", busy_o[2]); end
    idle(2, 40);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL false_start_word: got %0d words required 0", got_q.size()); end
    $display("false start rejected");
    send_frame(2, 16'h55, 1'b0, 2'b00, 1'b0, e);
    idle(2, 6);
    wait_word(e, "c4_frame");
  endtask

  task automatic test_break();
    word_t e;
    send_frame(0, 16'h41, 1'b0, 2'b01, 1'b0, e);
    repeat (20) begin
      @(posedge clk); #1;
      line[0] = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (busy_o[0] !== 1'b1) begin errors++; $display("FAIL break_busy: got %b required 1", busy_o[0]); end
    idle(0, 5);
    wait_word(e, "break");
    idle(0, 30);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL break_extra_word: got %0d words required 0", got_q.size()); end
  endtask

  task automatic test_overrun();
    word_t e;
    word_t e2;
    ready[0] = 1'b0;
    send_frame(0, 16'h12, 1'b0, 2'b00, 1'b0, e);
    idle(0, 2);
    send_frame(0, 16'h34, 1'b0, 2'b00, 1'b0, e2);
    idle(0, 3);
    wait_word(e, "overrun_held");
    @(negedge clk);
    checks++;
    if ({vld[0], ovr_o[0], dout[0]} !== {1'b1, 1'b1, 16'h12}) begin
      errors++;
      $display("FAIL overrun_state: got v=%b ovr=%b data=%h required v=1 ovr=1 data=0012", vld[0], ovr_o[0], dout[0]);
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL overrun_dropped: got %0d words required 0 (data %h)", got_q.size(), e2.data); end
    @(posedge clk); #1;
    ready[0] = 1'b1;
    @(posedge clk); #1;
    ready[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({vld[0], ovr_o[0]} !== 2'b00) begin
      errors++;
      $display("FAIL overrun_accept: got v=%b ovr=%b required v=0 ovr=0", vld[0], ovr_o[0]);
    end
    $display("overrun accepted");
  endtask

  task automatic test_back_to_back();
    word_t e;
    ready[0] = 1'b0;
    send_frame(0, 16'h12, 1'b0, 2'b00, 1'b0, e);
    idle(0, 2);
    wait_word(e, "b2b_first");
    send_frame(0, 16'h33, 1'b0, 2'b00, 1'b0, e);
    idle(0, 2);
    @(negedge clk);
    checks++;
    if (ovr_o[0] !== 1'b1) begin errors++; $display("FAIL b2b_overrun_set: got %b required 1", ovr_o[0]); end
    send_frame(0, 16'h56, 1'b0, 2'b00, 1'b1, e);
    wait_word(e, "b2b_same_cycle");
    checks++;
    if ({vld[0], ovr_o[0]} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_state: got v=%b ovr=%b required v=1 ovr=0", vld[0], ovr_o[0]);
    end
    @(posedge clk); #1;
    ready[0] = 1'b1;
    idle(0, 2);
  endtask

  task automatic test_reset_mid();
    word_t e;
    bit [4:0] part;
    ready[0] = 1'b0;
    send_frame(0, 16'h2A, 1'b0, 2'b00, 1'b0, e);
    idle(0, 2);
    wait_word(e, "pre_reset");
    part = 5'b10100;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      line[0] = part[k];
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    line[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({vld[0], perr_o[0], ferr_o[0], ovr_o[0], busy_o[0], dout[0]} !== 21'b0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b p=%b f=%b o=%b busy=%b data=%h required all 0",
               vld[0], perr_o[0], ferr_o[0], ovr_o[0], busy_o[0], dout[0]);
    end
    ready[0] = 1'b1;
    idle(0, 2);
    send_frame(0, 16'h41, 1'b0, 2'b00, 1'b0, e);
    idle(0, 3);
    wait_word(e, "post_reset");
  endtask

  task automatic test_random();
    word_t e;
    int insts[2] = '{0, 3};
    for (int j = 0; j < 2; j++) begin
      ready[insts[j]] = 1'b1;
      for (int f = 0; f < 12; f++) begin
        logic [15:0] d;
        bit pf;
        bit [1:0] sz;
        d  = 16'($urandom);
        pf = ($urandom_range(0, 3) == 0);
        sz = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        send_frame(insts[j], d, pf, sz, 1'b0, e);
        idle(insts[j], $urandom_range(1, 3));
        wait_word(e, "random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_false_start();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
